// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART transmitter: register map, bit indices, FSM states.
// The optional parity bit is enabled by defining UART_TX_PARITY_EN.
package apb_uart_pkg;

  localparam logic [1:0] RegStatus = 2'd0;
  localparam logic [1:0] RegTxdata = 2'd1;
  localparam logic [1:0] RegBaud   = 2'd2;
  localparam logic [1:0] RegCtrl   = 2'd3;

  localparam int unsigned StEmptyBit    = 0;
  localparam int unsigned StFullBit     = 1;
  localparam int unsigned StBusyBit     = 2;
  localparam int unsigned StOverflowBit = 3;

  localparam int unsigned CtrlTxEnBit      = 0;
  localparam int unsigned CtrlParityOddBit = 1;

  localparam logic [15:0] DEFAULT_DIV = 16'd867;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic            empty,
  output logic            full,
  output logic [PtrW:0]   count
);

  logic [7:0]      mem [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW+1)'(Depth));
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/apb_uart_tx_slave.sv
// APB completer with TX FIFO and 8N1 serialiser; stalls TXDATA writes while full and enabled.
// Defining UART_TX_PARITY_EN adds a parity bit (CTRL[1] selects odd) before the stop bit.
module apb_uart_tx_slave #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = apb_uart_pkg::DEFAULT_DIV
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx
);
  import apb_uart_pkg::*;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]      reg_sel;
  logic            access, commit;
  logic            wr_status, wr_txdata, wr_baud, wr_ctrl;
  logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [7:0]      fifo_dout;
  logic [CntW-1:0] fifo_count;
  logic [15:0]     baud_div_q;
  logic            tx_en_q, parity_odd_q, overflow_q, busy, bit_done;
  tx_state_e       state_q, state_d;
  logic [15:0]     baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            unused_ok;

  assign unused_ok = ^{PADDR[1:0], PWDATA[31:16]};

  assign reg_sel   = PADDR[3:2];
  assign access    = PSEL & PENABLE;
  assign PREADY    = ~(access & PWRITE & (reg_sel == RegTxdata) & fifo_full & tx_en_q);
  assign commit    = access & PREADY;
  assign wr_status = commit & PWRITE & (reg_sel == RegStatus);
  assign wr_txdata = commit & PWRITE & (reg_sel == RegTxdata);
  assign wr_baud   = commit & PWRITE & (reg_sel == RegBaud);
  assign wr_ctrl   = commit & PWRITE & (reg_sel == RegCtrl);
  assign fifo_push = wr_txdata & ~fifo_full;
  assign busy      = (state_q != StIdle);

  uart_tx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (PWDATA[7:0]),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      baud_div_q <= DEFAULT_DIV;
      tx_en_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_baud) baud_div_q <= PWDATA[15:0];
      if (wr_ctrl) tx_en_q <= PWDATA[CtrlTxEnBit];
      if (wr_status) begin
        overflow_q <= 1'b0;
      end else if (wr_txdata & fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      parity_odd_q <= 1'b0;
    end else if (wr_ctrl) begin
      parity_odd_q <= PWDATA[CtrlParityOddBit];
    end
  end
`else
  assign parity_odd_q = 1'b0;
`endif

  always_comb begin
    PRDATA = '0;
    if (PSEL & ~PWRITE) begin
      case (reg_sel)
        RegStatus: begin
          PRDATA[StEmptyBit]    = fifo_empty;
          PRDATA[StFullBit]     = fifo_full;
          PRDATA[StBusyBit]     = busy;
          PRDATA[StOverflowBit] = overflow_q;
          PRDATA[15:8]          = 8'(fifo_count);
        end
        RegBaud: PRDATA[15:0] = baud_div_q;
        RegCtrl: begin
          PRDATA[CtrlTxEnBit]      = tx_en_q;
          PRDATA[CtrlParityOddBit] = parity_odd_q;
        end
        default: PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
    end
  end

  // Compared against the live divider so a mid-bit change takes effect at once.
  assign bit_done = (baud_cnt_q >= baud_div_q);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    fifo_pop   = 1'b0;
    if (state_q != StIdle) begin
      baud_cnt_d = bit_done ? '0 : baud_cnt_q + 16'd1;
    end
    unique case (state_q)
      StIdle: begin
        if (tx_en_q & ~fifo_empty) begin
          fifo_pop   = 1'b1;
          data_d     = fifo_dout;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = StStart;
        end
      end
      StStart: if (bit_done) state_d = StData;
      StData: begin
        if (bit_done) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
      StParity: if (bit_done) state_d = StStop;
      StStop:   if (bit_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      StStart:  tx = 1'b0;
      StData:   tx = data_q[bit_cnt_q];
      StParity: tx = ^data_q ^ parity_odd_q;
      default:  tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_apb_uart_tx_slave.sv
// Scoreboard bench: accepted bytes queue expected frames; a line monitor decodes tx and compares.
module tb_apb_uart_tx_slave;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [3:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0, PENABLE = 1'b0, PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY, tx;

  apb_uart_tx_slave dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .tx      (tx)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic       exp_par_q[$];
  int         div_m = 867;
  logic       tx_en_m = 1'b0;
  logic       par_odd_m = 1'b0;
  int         held_m = 0;
  logic       mon_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data, output int stall);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    stall = 0;
    @(negedge PCLK);
    while (!PREADY && stall < 3000) begin
      stall++;
      @(negedge PCLK);
    end
    if (!PREADY) begin
      checks++; errors++;
      $display("FAIL pready_timeout addr=%h stalled %0d cycles, required completion", addr, stall);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    data = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(addr, d);
    chk(name, d, exp);
  endtask

  task automatic set_baud(input int div);
    int s;
    apb_write(4'h8, div, s);
    div_m = div;
  endtask

  task automatic set_ctrl(input logic en, input logic par);
    int s;
    apb_write(4'hC, {30'b0, par, en}, s);
    tx_en_m = en;
    par_odd_m = par;
    if (en) held_m = 0;
  endtask

  // A byte is dropped only when the FIFO is full with transmission disabled.
  task automatic send(input logic [7:0] b, output int stall);
    logic drop;
    drop = !tx_en_m && held_m >= 4;
    apb_write(4'h4, {24'b0, b}, stall);
    if (!drop) begin
      exp_q.push_back(b);
      exp_par_q.push_back(^b ^ par_odd_m);
      if (!tx_en_m) held_m++;
    end
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    int n;
    n = 0;
    apb_read(4'h0, d);
    while ((d[2:0] != 3'b001) && n < 2000) begin
      n++;
      apb_read(4'h0, d);
    end
    if (d[2:0] != 3'b001) begin
      checks++; errors++;
      $display("FAIL idle_timeout status=%08h, required empty and not busy", d);
    end
    repeat (3) @(posedge PCLK);
  endtask

  initial begin : monitor
    logic [7:0] mb;
    logic       mp;
    logic       bits [11];
    int         nb;
    logic       bad, abort;
    forever begin
      @(negedge PCLK);
      if (PRESETn === 1'b1 && tx === 1'b0) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame tx went low, required idle high");
          repeat ((div_m + 1) * 12) @(negedge PCLK);
        end else begin
          mb = exp_q.pop_front();
          mp = exp_par_q.pop_front();
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = mb[i];
`ifdef UART_TX_PARITY_EN
          bits[9] = mp; bits[10] = 1'b1; nb = 11;
`else
          bits[9] = 1'b1; bits[10] = 1'b1; nb = 10;
`endif
          abort = 1'b0;
          for (int k = 0; k < nb && !abort; k++) begin
            bad = 1'b0;
            for (int c = 0; c <= div_m; c++) begin
              if (k != 0 || c != 0) @(negedge PCLK);
              if (PRESETn !== 1'b1) begin
                abort = 1'b1;
                break;
              end
              if (tx !== bits[k]) bad = 1'b1;
            end
            if (!abort) begin
              checks++;
              if (bad) begin
                errors++;
                $display("FAIL frame_bit byte=%02h bit=%0d line deviated, required %0d for %0d cycles",
                         mb, k, bits[k], div_m + 1);
              end
            end
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stim
    int          s, last_stall, div;
    logic        par, hi_ok;
    logic [31:0] d;

    repeat (3) @(posedge PCLK);
    #1 chk("reset_tx_high", {31'b0, tx}, 32'h1);
    #2 PRESETn = 1'b1;
    read_chk("reset_status", 4'h0, 32'h0000_0001);
    read_chk("reset_baud", 4'h8, 32'd867);
    read_chk("reset_ctrl", 4'hC, 32'h0);
    read_chk("txdata_reads_zero", 4'h4, 32'h0);

    set_baud(3);
    read_chk("baud_rw", 4'h8, 32'd3);
    set_ctrl(1'b1, 1'b0);
    send(8'hA5, s);
    chk("a5_no_stall", s, 0);
    wait_idle();

    // Fill with transmission disabled: fifth byte is dropped and flags overflow.
    set_ctrl(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(8'($urandom), s);
      chk("fill_no_stall", s, 0);
    end
    read_chk("status_full_ovf", 4'h0, 32'h0000_040A);
    apb_write(4'h0, 32'h0, s);
    read_chk("status_ovf_cleared", 4'h0, 32'h0000_0402);
    set_ctrl(1'b1, 1'b0);
    wait_idle();

    // Enabled and full: the sixth write must wait for the serialiser to pop.
    last_stall = 0;
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), s);
      if (i < 5) chk("prefill_no_stall", s, 0);
      last_stall = s;
    end
    chk("stall_seen", {31'b0, last_stall > 0}, 32'h1);
    chk("stall_bounded", {31'b0, last_stall < 60}, 32'h1);
    read_chk("status_after_stall", 4'h0, 32'h0000_0406);
    wait_idle();

    // Reset in the middle of the data bits.
    send(8'h3C, s);
    repeat (20) @(posedge PCLK);
    #3 PRESETn = 1'b0;
    exp_q.delete();
    exp_par_q.delete();
    #1 chk("async_reset_tx_high", {31'b0, tx}, 32'h1);
    repeat (2) @(posedge PCLK);
    #3 PRESETn = 1'b1;
    div_m = 867; tx_en_m = 1'b0; par_odd_m = 1'b0; held_m = 0;
    read_chk("post_reset_status", 4'h0, 32'h0000_0001);
    read_chk("post_reset_baud", 4'h8, 32'd867);
    hi_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge PCLK);
      if (tx !== 1'b1) hi_ok = 1'b0;
    end
    chk("no_residual_frame", {31'b0, hi_ok}, 32'h1);

    for (int batch = 0; batch < 3; batch++) begin
      div = $urandom_range(1, 5);
      par = 1'($urandom_range(0, 1));
      set_baud(div);
      set_ctrl(1'b1, par);
`ifdef UART_TX_PARITY_EN
      read_chk("ctrl_readback", 4'hC, {30'b0, par, 1'b1});
`else
      read_chk("ctrl_readback", 4'hC, 32'h1);
`endif
      for (int n = 0; n < 10; n++) begin
        send(8'($urandom), s);
        repeat ($urandom_range(0, 30)) @(posedge PCLK);
      end
      wait_idle();
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("monitor_idle", {31'b0, mon_busy}, 32'h0);
    apb_read(4'h0, d);
    chk("final_status", d, 32'h0000_0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
